// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty instruction sequencer.
// Holds the fetch FSM encoding and the saturating counter helper.
package bitty_pkg;

  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_FIN   = 3'd5
  } fetch_state_e;

  // Completed-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [INSTR_W-1:0] sat_inc(input logic [INSTR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bitty_fetch_unit_if.sv
// Bus between the fetch unit, its instruction memory, the core and the controller.
// Master = fetch unit, slave = memory/core/controller side.
interface bitty_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  import bitty_pkg::*;

  // Protocol: mem_rd_data is valid exactly one cycle after a cycle with
  // mem_rd_en=1 (sync-read memory, no stall). run is held high for the whole
  // execution of one instruction; the core reports completion on core_done,
  // which only counts while run is high. start is only honoured while busy=0.
  logic                start;
  logic [ADDR_W-1:0]   last_addr;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [INSTR_W-1:0]  mem_rd_data;
  logic [INSTR_W-1:0]  instruction;
  logic                run;
  logic                core_done;
  logic                busy;
  logic                prog_done;
  logic [ADDR_W-1:0]   pc;
  logic [15:0]         instr_count;

  modport master (
    input  start, last_addr, mem_rd_data, core_done,
    output mem_rd_en, mem_addr, instruction, run, busy, prog_done, pc, instr_count
  );

  modport slave (
    output start, last_addr, mem_rd_data, core_done,
    input  mem_rd_en, mem_addr, instruction, run, busy, prog_done, pc, instr_count
  );

endinterface

// File: rtl/bitty_done_detect.sv
// Decides when the current instruction has finished executing: either on a
// fresh rising edge of core_done or after a fixed number of run cycles.
module bitty_done_detect #(
  parameter int DONE_MODE   = 0,
  parameter int EXEC_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic core_done,
  input  logic exec_active,
  input  logic exec_clear,
  output logic exec_complete
);

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  logic       done_q;
  logic       done_d;
  logic [3:0] exec_cnt_q;
  logic [3:0] exec_cnt_d;
  logic       edge_hit;
  logic       count_hit;

  always_comb begin
    done_d     = core_done;
    exec_cnt_d = exec_cnt_q;
    if (exec_clear) begin
      exec_cnt_d = '0;
    end else if (exec_active) begin
      exec_cnt_d = exec_cnt_q + 4'd1;
    end
  end

  // done_q tracks core_done in every state, so a level left high from the
  // previous instruction never looks like a new completion.
  assign edge_hit  = exec_active && core_done && !done_q;
  assign count_hit = exec_active && (exec_cnt_q == LAST_CNT);

  assign exec_complete = (DONE_MODE == 1) ? count_hit : edge_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q     <= 1'b0;
      exec_cnt_q <= '0;
    end else begin
      done_q     <= done_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

endmodule

// File: rtl/bitty_fetch_unit.sv
// Instruction sequencer: fetches words from address 0 up to a captured last
// address, hands each to the core on run, and pulses prog_done at the end.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DONE_MODE   = 0,
  parameter int EXEC_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  bitty_fetch_unit_if.master         bus,
  output fetch_state_e               fsm_state
);

  fetch_state_e        state_q;
  fetch_state_e        state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic [ADDR_W-1:0]   last_addr_q;
  logic [ADDR_W-1:0]   last_addr_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [INSTR_W-1:0]  instr_d;
  logic [15:0]         instr_count_q;
  logic [15:0]         instr_count_d;
  logic                exec_complete;

  bitty_done_detect #(
    .DONE_MODE   (DONE_MODE),
    .EXEC_CYCLES (EXEC_CYCLES)
  ) u_done_detect (
    .clk           (clk),
    .reset         (reset),
    .core_done     (bus.core_done),
    .exec_active   (state_q == ST_EXEC),
    .exec_clear    (state_q == ST_WAIT),
    .exec_complete (exec_complete)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    last_addr_d   = last_addr_q;
    instr_d       = instr_q;
    instr_count_d = instr_count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          last_addr_d   = bus.last_addr;
          pc_d          = '0;
          instr_count_d = '0;
          state_d       = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        instr_d = bus.mem_rd_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_complete) begin
          instr_count_d = sat_inc(instr_count_q);
          state_d       = ST_NEXT;
        end
      end
      // pc stops at last_addr_q, so it can never wrap past the top address.
      ST_NEXT: begin
        if (pc_q == last_addr_q) begin
          state_d = ST_FIN;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      last_addr_q   <= '0;
      instr_q       <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      last_addr_q   <= last_addr_d;
      instr_q       <= instr_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.mem_rd_en   = (state_q == ST_FETCH);
  assign bus.mem_addr    = pc_q;
  assign bus.instruction = instr_q;
  assign bus.run         = (state_q == ST_EXEC);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.prog_done   = (state_q == ST_FIN);
  assign bus.pc          = pc_q;
  assign bus.instr_count = instr_count_q;
  assign fsm_state       = state_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Bench for bitty_fetch_unit: a cycle-count instance checked every cycle
// against a timeline model, plus an edge-completion instance driven directly.
module tb_bitty_fetch_unit;
  import bitty_pkg::*;

  localparam int AW = 8;
  localparam int E  = 3;
  localparam int P  = E + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bitty_fetch_unit_if #(.ADDR_W(AW)) b1();
  bitty_fetch_unit_if #(.ADDR_W(AW)) b0();
  fetch_state_e st1;
  fetch_state_e st0;

  bitty_fetch_unit #(.ADDR_W(AW), .DONE_MODE(1), .EXEC_CYCLES(E)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.master), .fsm_state(st1)
  );
  bitty_fetch_unit #(.ADDR_W(AW), .DONE_MODE(0), .EXEC_CYCLES(E)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.master), .fsm_state(st0)
  );

  logic [15:0] mem1 [256];
  logic [15:0] mem0 [256];
  always @(posedge clk) if (b1.mem_rd_en) b1.mem_rd_data <= mem1[b1.mem_addr];
  always @(posedge clk) if (b0.mem_rd_en) b0.mem_rd_data <= mem0[b0.mem_addr];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [AW-1:0] exp_q[$];
  bit m_active = 1'b0;
  int m_cyc = 0;
  int m_last = 0;
  int m_pc_hold = 0;
  int m_cnt_hold = 0;
  int rd1 = 0;
  int run1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: every instruction occupies P cycles (fetch, wait, E run
  // cycles, next) and the program ends with one prog_done cycle.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_active = 1'b0;
      m_pc_hold = 0;
      m_cnt_hold = 0;
      exp_q.delete();
    end else if (!m_active) begin
      if (b1.start === 1'b1) begin
        m_active = 1'b1;
        m_cyc = 0;
        m_last = int'(b1.last_addr);
        for (int a = 0; a <= m_last; a++) exp_q.push_back(AW'(a));
      end
    end else if (m_cyc == (m_last + 1) * P) begin
      m_active = 1'b0;
      m_pc_hold = m_last;
      m_cnt_hold = m_last + 1;
    end else begin
      m_cyc++;
    end
  end

  initial begin : compare
    int idx;
    int ph;
    logic e_rd, e_run, e_busy, e_done;
    int e_pc, e_cnt;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (!m_active) begin
          e_rd = 0; e_run = 0; e_busy = 0; e_done = 0;
          e_pc = m_pc_hold; e_cnt = m_cnt_hold;
        end else if (m_cyc == (m_last + 1) * P) begin
          e_rd = 0; e_run = 0; e_busy = 1; e_done = 1;
          e_pc = m_last; e_cnt = m_last + 1;
        end else begin
          idx = m_cyc / P;
          ph  = m_cyc % P;
          e_rd = (ph == 0);
          e_run = (ph >= 2 && ph < 2 + E);
          e_busy = 1; e_done = 0;
          e_pc = idx;
          e_cnt = idx + ((ph == P - 1) ? 1 : 0);
        end
        chk("m_rd_en", 32'(b1.mem_rd_en), 32'(e_rd));
        chk("m_run", 32'(b1.run), 32'(e_run));
        chk("m_busy", 32'(b1.busy), 32'(e_busy));
        chk("m_prog_done", 32'(b1.prog_done), 32'(e_done));
        chk("m_pc", 32'(b1.pc), 32'(e_pc));
        chk("m_mem_addr", 32'(b1.mem_addr), 32'(e_pc));
        chk("m_instr_count", 32'(b1.instr_count), 32'(e_cnt));
        if (e_run) chk("m_instruction", 32'(b1.instruction), 32'(mem1[e_pc]));
        if (b1.mem_rd_en === 1'b1) begin
          if (exp_q.size() == 0) chk("sb_rd_extra", 32'(b1.mem_rd_en), 32'd0);
          else chk("sb_rd_addr", 32'(b1.mem_addr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (b1.mem_rd_en === 1'b1) rd1++;
    if (b1.run === 1'b1) run1++;
  end

  // ---------------- driver tasks ----------------
  task automatic start1(input int la);
    @(posedge clk); #1;
    b1.start = 1'b1; b1.last_addr = AW'(la);
    @(posedge clk); #1;
    b1.start = 1'b0;
  endtask

  task automatic start0(input int la);
    @(posedge clk); #1;
    b0.start = 1'b1; b0.last_addr = AW'(la);
    @(posedge clk); #1;
    b0.start = 1'b0;
  endtask

  // n = negedges after the first fetch cycle until prog_done is seen.
  task automatic wait_done(input bit sel, input int bound, output int n);
    n = 0;
    @(negedge clk);
    while ((sel ? b1.prog_done : b0.prog_done) !== 1'b1 && n < bound) begin
      n++;
      @(negedge clk);
    end
    if (n >= bound) chk("done_timeout", 32'(sel ? b1.prog_done : b0.prog_done), 32'd1);
  endtask

  task automatic wait_run(input bit sel, input int p, input int bound);
    int n = 0;
    @(negedge clk);
    while (!((sel ? b1.run : b0.run) === 1'b1 && int'(sel ? b1.pc : b0.pc) == p) && n < bound) begin
      n++;
      @(negedge clk);
    end
    if (n >= bound) chk("run_timeout", 32'(sel ? b1.run : b0.run), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int n;
    int snap;
    b1.start = 0; b1.last_addr = '0; b1.core_done = 0;
    b0.start = 0; b0.last_addr = '0; b0.core_done = 0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'(i * 16'h0111) ^ 16'h5A5A;
      mem0[i] = 16'(i * 16'h0203) ^ 16'h1234;
    end
    mem1[0] = 16'h2448; mem1[1] = 16'h4C50; mem1[2] = 16'h0000;
    mem0[0] = 16'hA001; mem0[1] = 16'hB002;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_busy1", 32'(b1.busy), 32'd0);
    chk("rst_run1", 32'(b1.run), 32'd0);
    chk("rst_pc1", 32'(b1.pc), 32'd0);
    chk("rst_instruction1", 32'(b1.instruction), 32'd0);
    chk("rst_count1", 32'(b1.instr_count), 32'd0);
    chk("rst_state0", 32'(st0), 32'(ST_IDLE));
    chk("rst_busy0", 32'(b0.busy), 32'd0);

    // Three-instruction program
    rd1 = 0; run1 = 0;
    start1(2);
    wait_done(1'b1, 100, n);
    chk("t1_cycles", n, 32'd18);
    chk("t1_pc", 32'(b1.pc), 32'd2);
    chk("t1_count", 32'(b1.instr_count), 32'd3);
    @(negedge clk);
    chk("t1_reads", rd1, 32'd3);
    chk("t1_run_cycles", run1, 32'd9);
    chk("t1_busy_after", 32'(b1.busy), 32'd0);

    // Single instruction program
    rd1 = 0; run1 = 0;
    start1(0);
    wait_done(1'b1, 50, n);
    chk("t2_cycles", n, 32'd6);
    chk("t2_pc", 32'(b1.pc), 32'd0);
    chk("t2_count", 32'(b1.instr_count), 32'd1);
    @(negedge clk);
    chk("t2_reads", rd1, 32'd1);
    chk("t2_run_cycles", run1, 32'd3);

    // start while busy is ignored
    rd1 = 0;
    start1(2);
    repeat (4) @(posedge clk);
    #1 b1.start = 1'b1; b1.last_addr = 8'd5;
    @(posedge clk); #1 b1.start = 1'b0;
    wait_done(1'b1, 100, n);
    chk("t3_pc", 32'(b1.pc), 32'd2);
    chk("t3_count", 32'(b1.instr_count), 32'd3);
    @(negedge clk);
    chk("t3_reads", rd1, 32'd3);
    chk("t3_busy_after", 32'(b1.busy), 32'd0);

    // reset during EXEC of address 1
    rd1 = 0;
    start1(2);
    wait_run(1'b1, 1, 100);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t4_run", 32'(b1.run), 32'd0);
    chk("t4_busy", 32'(b1.busy), 32'd0);
    chk("t4_pc", 32'(b1.pc), 32'd0);
    chk("t4_rd_en", 32'(b1.mem_rd_en), 32'd0);
    snap = rd1;
    chk("t4_reads_before", snap, 32'd2);
    repeat (10) @(negedge clk);
    chk("t4_no_more_reads", rd1, snap);
    chk("t4_idle", 32'(b1.busy), 32'd0);

    // reset and start together
    @(posedge clk); #1;
    reset = 1'b1; b1.start = 1'b1; b1.last_addr = 8'd1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(b1.busy), 32'd0);
    chk("t5_state", 32'(st1), 32'(ST_IDLE));
    @(posedge clk); #1 b1.start = 1'b0;
    @(negedge clk);
    chk("t5_fetch", 32'(b1.mem_rd_en), 32'd1);
    chk("t5_addr", 32'(b1.mem_addr), 32'd0);
    wait_done(1'b1, 100, n);
    chk("t5_count", 32'(b1.instr_count), 32'd2);

    // Edge-completion instance: held-high core_done must not complete
    b0.core_done = 1'b1;
    start0(1);
    wait_run(1'b0, 0, 50);
    repeat (8) begin
      @(negedge clk);
      chk("e_stall_run", 32'(b0.run), 32'd1);
      chk("e_stall_instr", 32'(b0.instruction), 32'hA001);
      chk("e_stall_count", 32'(b0.instr_count), 32'd0);
    end
    @(posedge clk); #1 b0.core_done = 1'b0;
    @(posedge clk); #1 b0.core_done = 1'b1;
    @(negedge clk);
    chk("e_before_edge_run", 32'(b0.run), 32'd1);
    @(negedge clk);
    chk("e_after_edge_run", 32'(b0.run), 32'd0);
    chk("e_after_edge_count", 32'(b0.instr_count), 32'd1);
    wait_run(1'b0, 1, 50);
    repeat (6) begin
      @(negedge clk);
      chk("e_stall2_run", 32'(b0.run), 32'd1);
      chk("e_stall2_instr", 32'(b0.instruction), 32'hB002);
      chk("e_stall2_count", 32'(b0.instr_count), 32'd1);
    end
    @(posedge clk); #1 b0.core_done = 1'b0;
    @(posedge clk); #1 b0.core_done = 1'b1;
    wait_done(1'b0, 50, n);
    chk("e_final_count", 32'(b0.instr_count), 32'd2);
    chk("e_final_pc", 32'(b0.pc), 32'd1);
    @(negedge clk);
    chk("e_idle", 32'(b0.busy), 32'd0);
    chk("sb_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
